dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV32I microcontroller: the memory-side end of the load/store path whose initiator is the register file and execute stage. It accepts one load or store request at a time over a valid/ready handshake and serves it from an internal word-organised array after a programmable number of wait states. Stores support byte, halfword and word sizes with lane steering; loads return sign- or zero-extended data. It returns a single response per request, with an error flag for illegal accesses.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two, 16..4096
- WAIT_STATES, 1, extra cycles between request accept and array access; 0..15

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset asserted when 0)
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1 (lbu/lhu); ignored for stores and words
- req_wdata  in  32  store data, right-aligned (rs2 value)
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  access was illegal; no array side effect

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch we/addr/size/unsigned/wdata.
  - Go to WAIT with wait counter = WAIT_STATES - 1, or straight to RESP when WAIT_STATES = 0.
- WAIT:
  - req_ready = 0; counter decrements each cycle.
  - On the cycle the counter is 0, perform the array access and go to RESP.
- Access when WAIT_STATES = 0: performed on the IDLE→RESP transition edge.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
- Word index = req_addr[31:2]. Index ≥ DEPTH_WORDS → rsp_err = 1, no write, rdata 0.
- req_size = 11 → rsp_err = 1, no access.
- Stores:
  - Byte: writes lane addr[1:0] with wdata[7:0].
  - Half: writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word: writes all four lanes.
  - Other lanes unchanged.
- Loads:
  - Extract the addressed byte or half from the read word.
  - Sign-extend when req_unsigned = 0, zero-extend when req_unsigned = 1.
  - Words are returned as read.
- The array is not cleared by reset; contents persist across reset.

## Timing
- Reset values: req_ready 0 during reset, 1 in the first cycle after reset deasserts (IDLE). rsp_valid 0, rsp_rdata 0, rsp_err 0, state IDLE, counter 0.
- Latency: request accepted at edge N → rsp_valid high from cycle N+1+WAIT_STATES.
- Throughput: next request is accepted no earlier than the cycle after the response handshake. req_ready is never high while rsp_valid is high.
- Backpressure: rsp_rdata and rsp_err stay constant while rsp_valid & !rsp_ready, for any number of cycles.
- Reset mid-operation: a pending request is dropped and no response is produced. If the array write edge coincides with a reset cycle, the write is suppressed.
- req_valid while req_ready = 0 is ignored; the initiator holds it.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - Half access with addr[0] = 1, or word access with addr[1:0] ≠ 00 → rsp_err = 1, no write, rdata 0.
- DMEM_MISALIGN_CHECK_EN undefined:
  - Low address bits are forced to alignment (half ignores addr[0], word ignores addr[1:0]).
  - The access proceeds and misalignment never raises rsp_err.

## Structure
- Package dmem_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL).
  - FSM state enum.
  - Lane-count constant.
- Sub-module dmem_lane_align, combinational:
  - Store side: generates the 4-bit byte-enable and lane-replicated write word from size/addr/wdata.
  - Load side: extracts and extends the read word.
- Top block holds the FSM, counter, request latches and the array.

## Test plan
- WAIT_STATES = 2, store word 0xDEADBEEF to 0x10, then load word 0x10 → rsp_valid exactly 3 cycles after each accept; rdata 0xDEADBEEF, err 0.
- Store byte 0x80 to 0x13 over word 0x00000000, then lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080; lw 0x10 → 0x80000000.
- With rsp_ready held 0 for 5 cycles → rsp_valid and rdata stable and req_ready 0 throughout; one handshake, then IDLE.
- Load from word index DEPTH_WORDS (addr 0x400 at 256 words), and req_size = 11 → err 1, rdata 0, no array change.
- DMEM_MISALIGN_CHECK_EN defined, sw to 0x12 → err 1, memory unchanged; undefined → word 0x10 written.
- Reset pulled low during WAIT of a store → no response, target word unchanged, req_ready 1 the cycle after reset releases.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
  localparam int LANES = 4;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_WAIT = ST_WAIT, S_RESP = ST_RESP} state_e;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between initiator and responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store byte-enable/lane replication and load extraction/extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e            size,
  input  logic [1:0]       addr_lo,
  input  logic             is_unsigned,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rword,
  output logic [LANES-1:0] be,
  output logic [31:0]      wword,
  output logic [31:0]      rdata
);
  logic [7:0]  rb;
  logic [15:0] rh;
  always_comb begin
    be = size == SZ_BYTE ? 4'b0001 << addr_lo :
         size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
         size == SZ_WORD ? 4'b1111 : 4'b0000;
    wword = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rb = rword[{addr_lo, 3'b000} +: 8];
    rh = addr_lo[1] ? rword[31:16] : rword[15:0];
    rdata = size == SZ_BYTE ? {{24{~is_unsigned & rb[7]}}, rb} :
            size == SZ_HALF ? {{16{~is_unsigned & rh[15]}}, rh} : rword;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated load/store responder over a word array; define
// DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  size_e            size_q, size_d;
  logic [31:0]      mem [DEPTH_WORDS];
  logic             idle, fire, acc, mis, oob, err, cur_we, cur_uns;
  logic [31:0]      cur_addr, cur_wdata, ld_data, wword;
  size_e            cur_size;
  logic [LANES-1:0] be;
  logic [AW-1:0]    idx;
  assign idle = state_q == ST_IDLE;
  assign bus.req_ready = idle & reset;
  assign bus.rsp_valid = state_q == ST_RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = err_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis = (cur_size == SZ_HALF && cur_addr[0]) || (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  dmem_lane_align u_align (
    .size(cur_size), .addr_lo(cur_addr[1:0]), .is_unsigned(cur_uns), .wdata(cur_wdata),
    .rword(mem[idx]), .be(be), .wword(wword), .rdata(ld_data)
  );
  // With zero wait states the access happens on the accept edge, so the live request is used.
  always_comb begin
    fire = bus.req_valid & bus.req_ready;
    cur_we = idle ? bus.req_we : we_q;
    cur_addr = idle ? bus.req_addr : addr_q;
    cur_size = idle ? size_e'(bus.req_size) : size_q;
    cur_uns = idle ? bus.req_unsigned : uns_q;
    cur_wdata = idle ? bus.req_wdata : wdata_q;
    idx = cur_addr[AW+1:2];
    oob = cur_addr[31:2] >= 30'(DEPTH_WORDS);
    err = cur_size == SZ_ILL || oob || mis;
    acc = idle ? fire && WAIT_STATES == 0 : state_q == ST_WAIT && cnt_q == 4'd0;
    state_d = idle ? (fire ? (WAIT_STATES == 0 ? ST_RESP : ST_WAIT) : ST_IDLE) :
              state_q == ST_WAIT ? (cnt_q == 4'd0 ? ST_RESP : ST_WAIT) :
              state_q == ST_RESP && !bus.rsp_ready ? ST_RESP : ST_IDLE;
    cnt_d = idle ? (fire && WAIT_STATES != 0 ? 4'(WAIT_STATES - 1) : 4'd0) :
            state_q == ST_WAIT && cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0;
    we_d = fire ? bus.req_we : we_q;
    addr_d = fire ? bus.req_addr : addr_q;
    size_d = fire ? size_e'(bus.req_size) : size_q;
    uns_d = fire ? bus.req_unsigned : uns_q;
    wdata_d = fire ? bus.req_wdata : wdata_q;
    rdata_d = acc ? (err || cur_we ? 32'd0 : ld_data) : rdata_q;
    err_d = acc ? err : err_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q <= 4'd0;
      we_q <= 1'b0;
      addr_q <= 32'd0;
      size_q <= SZ_BYTE;
      uns_q <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      size_q <= size_d;
      uns_q <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  // Array has no reset; a write landing on a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset && acc && cur_we && !err)
      for (int l = 0; l < LANES; l++)
        if (be[l]) mem[idx][8*l +: 8] <= wword[8*l +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table plus scoreboard for the data-memory responder
module tb_dmem_responder;
  localparam int WS = 2;
  localparam int DEPTH = 256;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] er;
    logic        ee;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  exp_t sb[$];
  dmem_responder_if bus ();
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata, input logic [31:0] er,
                              input logic ee);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata; v.er = er; v.ee = ee;
    return v;
  endfunction
  task automatic issue(input string tag, input vec_t v, input int hold);
    exp_t e;
    int n;
    sb.push_back('{v.er, v.ee});
    bus.req_valid = 1'b1;
    bus.req_we = v.we;
    bus.req_addr = v.addr;
    bus.req_size = v.size;
    bus.req_unsigned = v.uns;
    bus.req_wdata = v.wdata;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "/accept"}, {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'(WS + 1));
    chk({tag, "/ready_in_resp"}, {31'b0, bus.req_ready}, 32'd0);
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
      chk({tag, "/hold_rdata"}, bus.rsp_rdata, e.rdata);
      chk({tag, "/hold_ready"}, {31'b0, bus.req_ready}, 32'd0);
    end
    chk({tag, "/rdata"}, bus.rsp_rdata, e.rdata);
    chk({tag, "/err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "/rsp_done"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({tag, "/idle_ready"}, {31'b0, bus.req_ready}, 32'd1);
  endtask
  initial begin
    int quiet;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = 32'd0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_wdata = 32'd0;
    bus.rsp_ready = 1'b0;
    tbl.push_back(mk(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 32'h10, 2'b10, 0, 32'h00000000, 32'h0, 0));
    tbl.push_back(mk(1, 32'h13, 2'b00, 0, 32'h12345680, 32'h0, 0));
    tbl.push_back(mk(0, 32'h13, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0));
    tbl.push_back(mk(0, 32'h13, 2'b00, 1, 32'h0, 32'h00000080, 0));
    tbl.push_back(mk(0, 32'h10, 2'b10, 0, 32'h0, 32'h80000000, 0));
    tbl.push_back(mk(1, 32'h14, 2'b10, 0, 32'h11223344, 32'h0, 0));
    tbl.push_back(mk(1, 32'h16, 2'b01, 0, 32'hABCD8001, 32'h0, 0));
    tbl.push_back(mk(0, 32'h16, 2'b01, 0, 32'h0, 32'hFFFF8001, 0));
    tbl.push_back(mk(0, 32'h16, 2'b01, 1, 32'h0, 32'h00008001, 0));
    tbl.push_back(mk(0, 32'h14, 2'b01, 0, 32'h0, 32'h00003344, 0));
    tbl.push_back(mk(0, 32'h15, 2'b00, 0, 32'h0, 32'h00000033, 0));
    tbl.push_back(mk(0, 32'h14, 2'b10, 0, 32'h0, 32'h80013344, 0));
    tbl.push_back(mk(1, 32'h0, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0));
    tbl.push_back(mk(0, 32'h400, 2'b10, 0, 32'h0, 32'h0, 1));
    tbl.push_back(mk(1, 32'h400, 2'b10, 0, 32'h55555555, 32'h0, 1));
    tbl.push_back(mk(0, 32'h0, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0));
    tbl.push_back(mk(0, 32'h10, 2'b11, 0, 32'h0, 32'h0, 1));
    tbl.push_back(mk(1, 32'h10, 2'b11, 0, 32'h12345678, 32'h0, 1));
    tbl.push_back(mk(0, 32'h10, 2'b10, 0, 32'h0, 32'h80000000, 0));
`ifdef DMEM_MISALIGN_CHECK_EN
    tbl.push_back(mk(1, 32'h12, 2'b10, 0, 32'hA5A5A5A5, 32'h0, 1));
    tbl.push_back(mk(0, 32'h10, 2'b10, 0, 32'h0, 32'h80000000, 0));
`else
    tbl.push_back(mk(1, 32'h12, 2'b10, 0, 32'hA5A5A5A5, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 2'b10, 0, 32'h0, 32'hA5A5A5A5, 0));
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst/req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst/rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst/rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst/ready_after", {31'b0, bus.req_ready}, 32'd1);
    foreach (tbl[i]) issue($sformatf("vec%0d", i), tbl[i], 0);
    issue("backpressure", mk(0, 32'h14, 2'b10, 0, 32'h0, 32'h80013344, 0), 5);
    issue("pre_reset_sw", mk(1, 32'h20, 2'b10, 0, 32'h00000000, 32'h0, 0), 0);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 32'h20;
    bus.req_size = 2'b10;
    bus.req_wdata = 32'h99999999;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst/req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("midrst/rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst/ready_release", {31'b0, bus.req_ready}, 32'd1);
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) quiet++;
    end
    chk("midrst/no_response", 32'(quiet), 32'd0);
    issue("midrst_lw", mk(0, 32'h20, 2'b10, 0, 32'h0, 32'h00000000, 0), 0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
